rx_read_sched: RTL and testbench

Credit-based scheduler for TCP receive read requests in the top-k receive path. It accepts session notifications from the TCP stack, filters close and non-64-byte notifications, and issues read requests only while payload buffer space is available. Each issued request forwards its 88-bit notification as metadata to the downstream packet pairing stage. The in-flight count is returned by a per-packet completion pulse from the consumer.

---
 rtl/rx_read_sched_pkg.sv | 47 ++++
 rtl/rx_read_sched_sat_counter.sv | 21 ++
 rtl/rx_read_sched.sv | 196 +++++++++++++++++++
 tb/tb_rx_read_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_read_sched_pkg.sv
// rx_read_sched shared definitions.
// Notification layout, bundle widths and FSM encoding.
package rx_read_sched_pkg;

    localparam int NOTIF_W    = 88;
    localparam int READ_REQ_W = 32;

    localparam int SESSION_LSB = 0;
    localparam int SESSION_W   = 16;
    localparam int LEN_LSB     = 16;
    localparam int LEN_W       = 16;
    localparam int IP_LSB      = 32;
    localparam int PORT_LSB    = 64;
    localparam int CLOSED_BIT  = 80;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECIDE,
        S_WAIT_CREDIT,
        S_ISSUE
    } state_t;

    function automatic logic [LEN_W-1:0] notif_len(
        input logic [NOTIF_W-1:0] n
    );
        return n[LEN_LSB +: LEN_W];
    endfunction

    function automatic logic [SESSION_W-1:0] notif_session(
        input logic [NOTIF_W-1:0] n
    );
        return n[SESSION_LSB +: SESSION_W];
    endfunction

    function automatic logic notif_closed(
        input logic [NOTIF_W-1:0] n
    );
        return n[CLOSED_BIT];
    endfunction

    function automatic logic [READ_REQ_W-1:0] read_req(
        input logic [NOTIF_W-1:0] n
    );
        return {notif_len(n), notif_session(n)};
    endfunction

endpackage

// File: rtl/rx_read_sched_sat_counter.sv
// rx_read_sched saturating event counter.
// Increments on each pulse and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, holding at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_read_sched.sv
// rx_read_sched: credit-based TCP receive read scheduler.
// Filters notifications and issues read + meta while credit remains.
module rx_read_sched
    import rx_read_sched_pkg::*;
#(
    parameter int MAX_INFLIGHT = 16,
    parameter int PKT_BYTES    = 64,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [NOTIF_W-1:0]    s_axis_notifications_TDATA,
    input  logic                  s_axis_notifications_TVALID,
    output logic                  s_axis_notifications_TREADY,
    output logic [READ_REQ_W-1:0] m_axis_read_package_TDATA,
    output logic                  m_axis_read_package_TVALID,
    input  logic                  m_axis_read_package_TREADY,
    output logic [NOTIF_W-1:0]    m_axis_meta_TDATA,
    output logic                  m_axis_meta_TVALID,
    input  logic                  m_axis_meta_TREADY,
    input  logic                  pkt_done,
    output logic [CNT_W-1:0]      inflight,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           close_cnt,
    output logic                  err_underflow
);

    state_t                  state_q;
    state_t                  state_d;
    logic [NOTIF_W-1:0]      notif_q;
    logic [READ_REQ_W-1:0]   rd_data_q;
    logic                    rd_valid_q;
    logic                    rd_done_q;
    logic [NOTIF_W-1:0]      meta_data_q;
    logic                    meta_valid_q;
    logic                    meta_done_q;
    logic [CNT_W-1:0]        inflight_q;
    logic                    err_q;

    logic credit_ok;
    logic notif_hs;
    logic rd_hs;
    logic meta_hs;
    logic rd_fin;
    logic meta_fin;
    logic capture;
    logic load;
    logic issue_done;
    logic close_inc;
    logic drop_inc;

    assign credit_ok = inflight_q < CNT_W'(MAX_INFLIGHT);
    assign s_axis_notifications_TREADY = (state_q == S_IDLE) & cfg_enable;
    assign notif_hs = s_axis_notifications_TVALID & s_axis_notifications_TREADY;
    assign rd_hs    = rd_valid_q & m_axis_read_package_TREADY;
    assign meta_hs  = meta_valid_q & m_axis_meta_TREADY;
    assign rd_fin   = rd_done_q | rd_hs;
    assign meta_fin = meta_done_q | meta_hs;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        load       = 1'b0;
        issue_done = 1'b0;
        close_inc  = 1'b0;
        drop_inc   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (notif_hs) begin
                    capture = 1'b1;
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (notif_closed(notif_q) ||
                    (notif_len(notif_q) == '0)) begin
                    close_inc = 1'b1;
                    state_d   = S_IDLE;
                end else if (notif_len(notif_q) !=
                             LEN_W'(PKT_BYTES)) begin
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end else if (credit_ok) begin
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT_CREDIT;
                end
            end
            S_WAIT_CREDIT: begin
                if (credit_ok) begin
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rd_fin && meta_fin) begin
                    issue_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Notification capture and the two output channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            notif_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            meta_data_q  <= '0;
            meta_valid_q <= 1'b0;
            meta_done_q  <= 1'b0;
        end else begin
            if (capture) begin
                notif_q <= s_axis_notifications_TDATA;
            end
            if (load) begin
                rd_data_q    <= read_req(notif_q);
                meta_data_q  <= notif_q;
                rd_valid_q   <= 1'b1;
                meta_valid_q <= 1'b1;
                rd_done_q    <= 1'b0;
                meta_done_q  <= 1'b0;
            end else begin
                if (rd_hs) begin
                    rd_valid_q <= 1'b0;
                    rd_done_q  <= 1'b1;
                end
                if (meta_hs) begin
                    meta_valid_q <= 1'b0;
                    meta_done_q  <= 1'b1;
                end
                if (issue_done) begin
                    rd_done_q   <= 1'b0;
                    meta_done_q <= 1'b0;
                end
            end
        end
    end

    // Outstanding-request credit count and underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case ({issue_done, pkt_done})
                2'b10: inflight_q <= inflight_q + 1'b1;
                2'b01: begin
                    if (inflight_q == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        inflight_q <= inflight_q - 1'b1;
                    end
                end
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    sat_counter #(.W(32)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    sat_counter #(.W(32)) u_close_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (close_inc),
        .count (close_cnt)
    );

    assign m_axis_read_package_TDATA  = rd_data_q;
    assign m_axis_read_package_TVALID = rd_valid_q;
    assign m_axis_meta_TDATA          = meta_data_q;
    assign m_axis_meta_TVALID         = meta_valid_q;
    assign inflight                   = inflight_q;
    assign err_underflow              = err_q;

endmodule

// File: tb/tb_rx_read_sched.sv
// rx_read_sched bench.
// Scoreboard queues filled at issue, drained by a monitor.
module tb_rx_read_sched;

    localparam int CNT_W = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic [87:0] n_data;
    logic        n_valid;
    logic        n_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [87:0] meta_data;
    logic        meta_valid;
    logic        meta_ready;
    logic        pkt_done;
    logic [CNT_W-1:0] inflight;
    logic [31:0] drop_cnt;
    logic [31:0] close_cnt;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;
    int rd_hs_cnt = 0;
    int meta_hs_cnt = 0;

    logic [31:0] rd_q[$];
    logic [87:0] meta_q[$];

    always #5 clk = ~clk;

    rx_read_sched dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .cfg_enable                  (cfg_enable),
        .s_axis_notifications_TDATA  (n_data),
        .s_axis_notifications_TVALID (n_valid),
        .s_axis_notifications_TREADY (n_ready),
        .m_axis_read_package_TDATA   (rd_data),
        .m_axis_read_package_TVALID  (rd_valid),
        .m_axis_read_package_TREADY  (rd_ready),
        .m_axis_meta_TDATA           (meta_data),
        .m_axis_meta_TVALID          (meta_valid),
        .m_axis_meta_TREADY          (meta_ready),
        .pkt_done                    (pkt_done),
        .inflight                    (inflight),
        .drop_cnt                    (drop_cnt),
        .close_cnt                   (close_cnt),
        .err_underflow               (err_underflow)
    );

    task automatic chk(input string name, input logic [87:0] act,
                       input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [87:0] mk(input logic [15:0] sess,
                                        input logic [15:0] len,
                                        input logic closed);
        return {7'd0, closed, 16'h1F90, 16'hC0A8, sess, len, sess};
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one notification; queue expectations if it should issue.
    task automatic send(input logic [15:0] sess, input logic [15:0] len,
                        input logic closed);
        logic [87:0] d;
        bit ok;
        d = mk(sess, len, closed);
        if (len == 16'd64 && !closed) begin
            rd_q.push_back({len, sess});
            meta_q.push_back(d);
        end
        n_data = d;
        n_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (n_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        n_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout session=%0h", sess);
        end
    endtask

    task automatic pulse_done(input int n);
        for (int i = 0; i < n; i++) begin
            pkt_done = 1'b1;
            cyc(1);
            pkt_done = 1'b0;
        end
    endtask

    // Pop and compare on every output handshake; check stall stability.
    task automatic monitor();
        logic        hold;
        logic [87:0] held;
        hold = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("meta_stable_valid", {87'd0, meta_valid}, 88'd1);
                    chk("meta_stable_data", meta_data, held);
                end
                hold = meta_valid && !meta_ready;
                held = meta_data;
                if (rd_valid && rd_ready) begin
                    rd_hs_cnt++;
                    if (rd_q.size() == 0) begin
                        chk("rd_unexpected", {56'd0, rd_data}, 88'd0);
                    end else begin
                        chk("rd_data", {56'd0, rd_data},
                            {56'd0, rd_q.pop_front()});
                    end
                end
                if (meta_valid && meta_ready) begin
                    meta_hs_cnt++;
                    if (meta_q.size() == 0) begin
                        chk("meta_unexpected", meta_data, 88'd0);
                    end else begin
                        chk("meta_data", meta_data, meta_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, {87'd0, n_ready}, 88'd0);
        chk({tag, "_rd_valid"}, {87'd0, rd_valid}, 88'd0);
        chk({tag, "_meta_valid"}, {87'd0, meta_valid}, 88'd0);
        chk({tag, "_rd_data"}, {56'd0, rd_data}, 88'd0);
        chk({tag, "_meta_data"}, meta_data, 88'd0);
        chk({tag, "_inflight"}, {83'd0, inflight}, 88'd0);
        chk({tag, "_drop"}, {56'd0, drop_cnt}, 88'd0);
        chk({tag, "_close"}, {56'd0, close_cnt}, 88'd0);
        chk({tag, "_err"}, {87'd0, err_underflow}, 88'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_enable = 1'b0;
        n_data = '0;
        n_valid = 1'b0;
        rd_ready = 1'b0;
        meta_ready = 1'b0;
        pkt_done = 1'b0;
        fork
            monitor();
        join_none

        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        cfg_enable = 1'b1;
        rd_ready = 1'b1;
        meta_ready = 1'b1;

        // Single notification, latency and credit return.
        send(16'h0005, 16'd64, 1'b0);
        chk("lat_t1_idle", {87'd0, rd_valid}, 88'd0);
        cyc(1);
        chk("lat_t2_rd", {87'd0, rd_valid}, 88'd1);
        chk("lat_t2_meta", {87'd0, meta_valid}, 88'd1);
        chk("lat_t2_rd_data", {56'd0, rd_data}, 88'h00400005);
        cyc(1);
        chk("single_inflight", {83'd0, inflight}, 88'd1);
        pulse_done(1);
        chk("single_return", {83'd0, inflight}, 88'd0);

        // Filtered notifications.
        send(16'h0011, 16'd128, 1'b0);
        send(16'h0012, 16'd0, 1'b0);
        send(16'h0013, 16'd64, 1'b1);
        cyc(3);
        chk("filt_drop", {56'd0, drop_cnt}, 88'd1);
        chk("filt_close", {56'd0, close_cnt}, 88'd2);
        chk("filt_rd_hs", rd_hs_cnt, 1);

        // Credit exhaustion: 17 notifications, 16 issue.
        for (int i = 0; i < 17; i++) begin
            send(16'h0100 + 16'(i), 16'd64, 1'b0);
        end
        cyc(10);
        chk("cred_rd_hs", rd_hs_cnt, 17);
        chk("cred_inflight", {83'd0, inflight}, 88'd16);
        chk("cred_stall_tready", {87'd0, n_ready}, 88'd0);
        chk("cred_stall_valid", {87'd0, rd_valid}, 88'd0);
        pulse_done(1);
        cyc(6);
        chk("cred_release_rd", rd_hs_cnt, 18);
        chk("cred_release_meta", meta_hs_cnt, 18);
        chk("cred_refill", {83'd0, inflight}, 88'd16);
        pulse_done(16);
        chk("cred_drain", {83'd0, inflight}, 88'd0);

        // Meta channel back-pressure.
        meta_ready = 1'b0;
        send(16'h0007, 16'd64, 1'b0);
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("bp_meta_valid", {87'd0, meta_valid}, 88'd1);
            chk("bp_rd_valid", {87'd0, rd_valid}, 88'd0);
            chk("bp_inflight", {83'd0, inflight}, 88'd0);
        end
        meta_ready = 1'b1;
        chk("bp_pre_inflight", {83'd0, inflight}, 88'd0);
        cyc(1);
        chk("bp_post_inflight", {83'd0, inflight}, 88'd1);
        chk("bp_rd_once", rd_hs_cnt, 19);
        chk("bp_meta_once", meta_hs_cnt, 19);

        // Simultaneous completion and pkt_done at inflight 3.
        send(16'h0021, 16'd64, 1'b0);
        cyc(3);
        send(16'h0022, 16'd64, 1'b0);
        cyc(3);
        chk("sim_pre", {83'd0, inflight}, 88'd3);
        send(16'h0023, 16'd64, 1'b0);
        cyc(1);
        pkt_done = 1'b1;
        cyc(1);
        pkt_done = 1'b0;
        chk("sim_hold", {83'd0, inflight}, 88'd3);
        pulse_done(3);
        chk("under_pre_err", {87'd0, err_underflow}, 88'd0);
        pulse_done(1);
        chk("under_err", {87'd0, err_underflow}, 88'd1);
        chk("under_inflight", {83'd0, inflight}, 88'd0);

        // Asynchronous reset during ISSUE.
        rd_ready = 1'b0;
        meta_ready = 1'b0;
        send(16'h0009, 16'd64, 1'b0);
        cyc(1);
        chk("arst_pre_valid", {87'd0, rd_valid}, 88'd1);
        #2;
        rst_n = 1'b0;
        cfg_enable = 1'b0;
        #1;
        chk_reset_outputs("arst");
        rd_q.delete();
        meta_q.delete();
        cyc(2);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        cfg_enable = 1'b1;
        rd_ready = 1'b1;
        meta_ready = 1'b1;
        send(16'h00AB, 16'd64, 1'b0);
        cyc(4);
        chk("post_rst_rd_hs", rd_hs_cnt, 23);
        chk("post_rst_inflight", {83'd0, inflight}, 88'd1);

        cyc(3);
        chk("rd_q_empty", rd_q.size(), 0);
        chk("meta_q_empty", meta_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
